// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters, with a one-entry tagged response register.
// Optional signed-overflow output rsp_ovf_out is enabled by defining ADD_ARB_OVF_EN.
module add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [NREQ-1:0]         req_valid_in,
    output logic [NREQ-1:0]         req_ready_out,
    input  logic [NREQ*WIDTH-1:0]   req_a_in,
    input  logic [NREQ*WIDTH-1:0]   req_b_in,
    output logic                    rsp_valid_out,
    input  logic                    rsp_ready_in,
    output logic [IDW-1:0]          rsp_id_out,
    output logic [WIDTH-1:0]        rsp_sum_out,
    output logic                    rsp_carry_out,
`ifdef ADD_ARB_OVF_EN
    output logic                    rsp_ovf_out,
`endif
    output logic [15:0]             stall_cnt_out
);

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [15:0]      stall_q, stall_d;
`ifdef ADD_ARB_OVF_EN
    logic             rsp_ovf_q, rsp_ovf_d;
`endif

    logic             accept;
    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     cand;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH:0]   sum_ext;
    logic             ovf;

    // Priority search starting at rr_ptr; cand is one bit wider so the wrap subtract never overflows.
    always_comb begin
        accept    = !rsp_valid_q || rsp_ready_in;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_vld && req_valid_in[cand[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
        if (!accept || !rst_n_in) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready_out = '0;
        if (grant_vld) begin
            req_ready_out[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        a_sel   = req_a_in[grant_idx*WIDTH +: WIDTH];
        b_sel   = req_b_in[grant_idx*WIDTH +: WIDTH];
        sum_ext = {1'b0, a_sel} + {1'b0, b_sel};
        ovf     = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum_ext[WIDTH-1] != a_sel[WIDTH-1]);
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        stall_d     = stall_q;
`ifdef ADD_ARB_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        if (grant_vld) begin
            rr_ptr_d    = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_sum_d   = sum_ext[WIDTH-1:0];
            rsp_carry_d = sum_ext[WIDTH];
`ifdef ADD_ARB_OVF_EN
            rsp_ovf_d   = ovf;
`endif
        end else if (rsp_ready_in) begin
            rsp_valid_d = 1'b0;
        end
        if (|req_valid_in && !accept && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            stall_q     <= '0;
`ifdef ADD_ARB_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            stall_q     <= stall_d;
`ifdef ADD_ARB_OVF_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    assign rsp_valid_out = rsp_valid_q;
    assign rsp_id_out    = rsp_id_q;
    assign rsp_sum_out   = rsp_sum_q;
    assign rsp_carry_out = rsp_carry_q;
    assign stall_cnt_out = stall_q;
`ifdef ADD_ARB_OVF_EN
    assign rsp_ovf_out   = rsp_ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: hand-written vectors and sequences plus randomized traffic against a reference model.
module tb_add_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk_in = 1'b0;
    logic                  rst_n_in;
    logic [NREQ-1:0]       req_valid_in;
    logic [NREQ-1:0]       req_ready_out;
    logic [NREQ*WIDTH-1:0] req_a_in, req_b_in;
    logic                  rsp_valid_out, rsp_ready_in, rsp_carry_out;
    logic [IDW-1:0]        rsp_id_out;
    logic [WIDTH-1:0]      rsp_sum_out;
    logic [15:0]           stall_cnt_out;
`ifdef ADD_ARB_OVF_EN
    logic                  rsp_ovf_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req_a_in      (req_a_in),
        .req_b_in      (req_b_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_id_out    (rsp_id_out),
        .rsp_sum_out   (rsp_sum_out),
        .rsp_carry_out (rsp_carry_out),
`ifdef ADD_ARB_OVF_EN
        .rsp_ovf_out   (rsp_ovf_out),
`endif
        .stall_cnt_out (stall_cnt_out)
    );

    // Requester-side view
    bit               vld [NREQ];
    logic [WIDTH-1:0] op_a[NREQ];
    logic [WIDTH-1:0] op_b[NREQ];

    // Reference model of the observable state
    int               m_ptr, m_id, m_stall;
    bit               m_vld, m_carry;
    logic [WIDTH-1:0] m_sum;
`ifdef ADD_ARB_OVF_EN
    bit               m_ovf, s_ovf;
`endif

    // DUT values captured at the last negedge
    logic [NREQ-1:0]  s_ready;
    logic             s_vld, s_carry;
    logic [IDW-1:0]   s_id;
    logic [WIDTH-1:0] s_sum;
    logic [15:0]      s_stall;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        bit               carry;
        bit               ovf;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid_in[i]              = vld[i];
            req_a_in[i*WIDTH +: WIDTH]   = op_a[i];
            req_b_in[i*WIDTH +: WIDTH]   = op_b[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_id = 0; m_stall = 0; m_vld = 0; m_carry = 0; m_sum = '0;
`ifdef ADD_ARB_OVF_EN
        m_ovf = 0;
`endif
    endtask

    function automatic int model_grant();
        if (m_vld && !rsp_ready_in) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: compare at negedge, advance the model at posedge, return just after it.
    task automatic tick(output int g);
        logic [WIDTH:0] wide;
        longint         sa, sb, lim;
        bit             any;
        drive();
        @(negedge clk_in);
        g = model_grant();
        s_ready = req_ready_out; s_vld = rsp_valid_out; s_id = rsp_id_out;
        s_sum = rsp_sum_out; s_carry = rsp_carry_out; s_stall = stall_cnt_out;
        check("grant", s_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        check("rsp_valid", s_vld, m_vld);
        check("rsp_id", s_id, m_id);
        check("rsp_sum", s_sum, m_sum);
        check("rsp_carry", s_carry, m_carry);
        check("stall_cnt", s_stall, m_stall);
`ifdef ADD_ARB_OVF_EN
        s_ovf = rsp_ovf_out;
        check("rsp_ovf", s_ovf, m_ovf);
`endif
        @(posedge clk_in);
        any = 0;
        for (int i = 0; i < NREQ; i++) any |= vld[i];
        if (any && m_vld && !rsp_ready_in && m_stall < 65535) m_stall++;
        if (g >= 0) begin
            wide    = {1'b0, op_a[g]} + {1'b0, op_b[g]};
            m_sum   = wide[WIDTH-1:0];
            m_carry = wide[WIDTH];
            m_id    = g;
            m_vld   = 1;
            m_ptr   = (g + 1) % NREQ;
            sa  = longint'($signed(op_a[g]));
            sb  = longint'($signed(op_b[g]));
            lim = longint'(1) << (WIDTH - 1);
`ifdef ADD_ARB_OVF_EN
            m_ovf = (sa + sb >= lim) || (sa + sb < -lim);
`endif
        end else if (rsp_ready_in) begin
            m_vld = 0;
        end
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 0; op_a[i] = '0; op_b[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        clear_reqs();
        rsp_ready_in = 1'b1;
        drive();
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    initial begin
        int g;
        logic [15:0] st0;
        tbl[0] = '{2, 32'h0000_0004, 32'h0040_0000, 32'h0040_0004, 1'b0, 1'b0};
        tbl[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};
        tbl[5] = '{2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1, 1'b0};

        rst_n_in = 1'b0;
        clear_reqs();
        vld[1] = 1;
        rsp_ready_in = 1'b1;
        drive();
        #2;
        check("reset_ready", req_ready_out, 0);
        check("reset_valid", rsp_valid_out, 0);
        check("reset_stall", stall_cnt_out, 0);
        do_reset();

        // Single-request vectors: grant same cycle, tagged result next cycle
        foreach (tbl[e]) begin
            clear_reqs();
            vld[tbl[e].id] = 1; op_a[tbl[e].id] = tbl[e].a; op_b[tbl[e].id] = tbl[e].b;
            tick(g);
            check("tbl_grant", s_ready, 64'd1 << tbl[e].id);
            vld[tbl[e].id] = 0;
            tick(g);
            check("tbl_valid", s_vld, 1);
            check("tbl_id", s_id, tbl[e].id);
            check("tbl_sum", s_sum, tbl[e].sum);
            check("tbl_carry", s_carry, tbl[e].carry);
`ifdef ADD_ARB_OVF_EN
            check("tbl_ovf", s_ovf, tbl[e].ovf);
`endif
        end

        // After a grant to 2 the pointer sits at 3
        do_reset();
        vld[2] = 1; op_a[2] = 32'd4; op_b[2] = 32'h40_0000;
        tick(g);
        vld[2] = 0;
        for (int i = 0; i < NREQ; i++) vld[i] = 1;
        tick(g);
        check("ptr_after_2", s_ready, 4'b1000);

        // All valid continuously: strict rotation, one response per cycle
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1; op_a[i] = 32'(i * 100); op_b[i] = 32'(i);
        end
        for (int c = 0; c < 9; c++) begin
            tick(g);
            if (c < 8) check("rr_grant", s_ready, 64'd1 << (c % 4));
            if (c > 0) begin
                check("rr_valid", s_vld, 1);
                check("rr_id", s_id, (c - 1) % 4);
                check("rr_sum", s_sum, ((c - 1) % 4) * 101);
            end
        end

        // Back-pressure: five held cycles, then 1 before 3
        do_reset();
        vld[0] = 1; op_a[0] = 32'd10; op_b[0] = 32'd20;
        tick(g);
        vld[0] = 0;
        vld[1] = 1; op_a[1] = 32'd7; op_b[1] = 32'd8;
        vld[3] = 1; op_a[3] = 32'd1; op_b[3] = 32'd2;
        rsp_ready_in = 1'b0;
        st0 = 16'd0;
        for (int c = 0; c < 5; c++) begin
            tick(g);
            if (c == 0) st0 = s_stall;
            check("bp_grant", s_ready, 0);
            check("bp_valid", s_vld, 1);
            check("bp_id", s_id, 0);
            check("bp_sum", s_sum, 30);
        end
        rsp_ready_in = 1'b1;
        tick(g);
        check("bp_stall_delta", s_stall - st0, 5);
        check("bp_first", s_ready, 4'b0010);
        vld[1] = 0;
        tick(g);
        check("bp_second", s_ready, 4'b1000);
        check("bp_rsp_id", s_id, 1);

        // Asynchronous reset while a response is held
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1; op_a[i] = 32'(i + 5); op_b[i] = 32'(i + 9);
        end
        tick(g);
        tick(g);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid_out, 0);
        check("mid_rst_sum", rsp_sum_out, 0);
        check("mid_rst_id", rsp_id_out, 0);
        check("mid_rst_carry", rsp_carry_out, 0);
        check("mid_rst_ready", req_ready_out, 0);
        model_reset();
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
        tick(g);
        check("mid_rst_restart", s_ready, 4'b0001);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rsp_ready_in = ($urandom_range(3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] && $urandom_range(2) == 0) begin
                    vld[i] = 1;
                    op_a[i] = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    op_b[i] = $urandom;
                end
            end
            tick(g);
            if (g >= 0) vld[g] = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that shares a single WIDTH-bit adder among NREQ requesters. These are, for example, PC-increment, branch-target and address-generation clients in a multicycle or shared-resource datapath. Each cycle it grants at most one requester and computes that requester's sum on the one adder. It returns the result through a one-entry registered response stage tagged with the requester index.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- WIDTH, default 32: operand and sum width.
- IDW, default 2: requester-index width, equal to ceil(log2(NREQ)).
- clk_in, input, 1: clock; all state updates on the rising edge.
- rst_n_in, input, 1: reset, asynchronous, active-low.
- req_valid_in, input, NREQ: bit i means requester i presents an operand pair.
- req_ready_out, output, NREQ: one-hot grant; bit i high means requester i's pair is taken this cycle.
- req_a_in, input, NREQ*WIDTH: operand A, with requester i at bits [i*WIDTH +: WIDTH].
- req_b_in, input, NREQ*WIDTH: operand B, packed the same way.
- rsp_valid_out, output, 1: a response is held.
- rsp_ready_in, input, 1: the consumer accepts the response.
- rsp_id_out, output, IDW: index of the requester that produced the response.
- rsp_sum_out, output, WIDTH: (A + B) mod 2^WIDTH.
- rsp_carry_out, output, 1: unsigned carry out of bit WIDTH-1.
- stall_cnt_out, output, 16: saturating count of cycles in which any request was valid but none was granted.

## Operation
- **Handshakes.** A request transfers when req_valid_in[i] and req_ready_out[i] are both high. A response transfers when rsp_valid_out and rsp_ready_in are both high.
- **Requester rules.**
  - Once valid is asserted, the requester holds valid, A and B stable until granted.
  - The requester must not deassert valid before the grant.
- **Accept condition.** accept = !rsp_valid_out || rsp_ready_in. No grant is issued when accept is 0.
- **Grant selection.**
  - rr_ptr (IDW bits) marks the highest-priority index.
  - When accept = 1, the grant goes to the first i with req_valid_in[i] high, searching rr_ptr, rr_ptr+1, … NREQ-1, 0, …, with wrap-around modulo NREQ.
  - req_ready_out is combinational from req_valid_in, rr_ptr and accept. It is at most one-hot.
- **On a grant to index g:**
  - rr_ptr becomes (g+1) mod NREQ.
  - The response register loads sum, carry and id = g, and rsp_valid_out becomes 1.
- **No grant, response drained:** if rsp_ready_in is high, rsp_valid_out becomes 0. rsp_sum_out, rsp_carry_out and rsp_id_out keep their previous values.
- **No grant, nothing to drain:** rr_ptr is unchanged.
- **Simultaneous drain and grant:** the new response replaces the old one in the same edge, and rsp_valid_out stays 1. This sustains full throughput of one sum per cycle.
- **Adder use.** Exactly one adder is instantiated. Its operands are muxed from the granted requester.
- **Fairness.** A continuously valid requester is granted within NREQ accepted transfers.
- **stall_cnt_out.** Increments when |req_valid_in && !accept, and saturates at 16'hFFFF.

## Timing
- **Reset values** (asynchronous on rst_n_in low; released synchronously to clk_in):
  - rsp_valid_out = 0, rsp_sum_out = 0, rsp_carry_out = 0, rsp_id_out = 0.
  - rr_ptr = 0, stall_cnt_out = 0.
  - req_ready_out = 0 while in reset.
- **Latency.**
  - The grant is in cycle N.
  - The response is visible after the rising edge ending cycle N, so it is valid in cycle N+1.
  - Request to response latency is 1 cycle.
- **Back-pressure.** While rsp_ready_in is low and rsp_valid_out is high, no grant is issued. All outputs hold.
- **Reset mid-operation.**
  - A pending response is discarded, not replayed.
  - Requesters keep valid asserted and are re-arbitrated from rr_ptr = 0 after reset.
- There are no combinational paths from rsp_ready_in to the rsp_* outputs. A path from rsp_ready_in to req_ready_out is allowed.

## Configuration
- **ADD_ARB_OVF_EN defined:**
  - Adds output rsp_ovf_out (1 bit), the signed two's-complement overflow of A+B. It is set when A and B have equal sign bits and the sum's sign bit differs.
  - rsp_ovf_out is registered with the response, with reset value 0.
- **ADD_ARB_OVF_EN undefined:** the port and its register do not exist. All other behaviour is identical.

## Test plan
- **Single request:** after reset, requester 2 presents A=32'h0000_0004, B=32'h0040_0000 with rsp_ready_in=1. Required: grant in the same cycle; next cycle rsp_valid_out=1, id=2, sum=32'h0040_0004, carry=0; rr_ptr=3.
- **Wrap-around:** A=32'hFFFF_FFFF, B=32'h0000_0001. Required: sum=0, carry=1. With ADD_ARB_OVF_EN, ovf=0. A=32'h7FFF_FFFF, B=1 gives ovf=1.
- **All four valid with rsp_ready_in=1 for 8 cycles:**
  - Required grant order is 0,1,2,3,0,1,2,3, with one response per cycle.
  - Ids match the grant order, and no requester is skipped.
- **Back-pressure:** hold rsp_ready_in=0 for 5 cycles with a response held and requesters 1 and 3 valid.
  - Required: no grants, and the outputs stay stable.
  - stall_cnt_out increases by 5.
  - On release, requester 1 is granted before requester 3.
- **Reset mid-stream:** assert rst_n_in low asynchronously between edges while rsp_valid_out=1. Required: all outputs go to their reset values immediately; after release, arbitration restarts at index 0.
